// File: rtl/note_sequencer.sv
// ----------------------------------------------------------------------------
// note_sequencer
//
// Initiator side of the note-player load handshake. Walks a song ROM one
// entry at a time, decodes each 16-bit entry into note / duration / stereo
// side, presents it to the note player with a single-cycle load pulse and
// then waits for the player's done pulse before fetching the next entry.
//
// Song entry layout (rom_data):
//   [15]    end-of-song marker
//   [14:13] stereo side, one-hot
//   [12:7]  note
//   [6:1]   duration in beats
//   [0]     reserved, ignored
//
// Ports:
//   clk                 system clock, rising edge
//   reset_n             asynchronous active-low reset
//   play                run enable (level), also forwarded as play_enable
//   restart             synchronous single-cycle rewind to entry 0
//   rom_addr            song ROM address (ROM has 1-cycle read latency)
//   rom_data            song ROM read data
//   note_to_load        registered note field
//   duration_to_load    registered duration field
//   stereo_side_to_load registered stereo side field
//   load_new_note       one-cycle pulse, fields valid in the same cycle
//   done_with_note      single-cycle pulse from the player
//   play_enable         registered copy of play
//   song_done           high from song end until restart or reset
// ----------------------------------------------------------------------------
module note_sequencer #(
    parameter int SONG_ADDR_W = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   play,
    input  logic                   restart,
    output logic [SONG_ADDR_W-1:0] rom_addr,
    input  logic [15:0]            rom_data,
    output logic [5:0]             note_to_load,
    output logic [5:0]             duration_to_load,
    output logic [1:0]             stereo_side_to_load,
    output logic                   load_new_note,
    input  logic                   done_with_note,
    output logic                   play_enable,
    output logic                   song_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        LOAD      = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t state_r;

    // Field decode of the current ROM word.
    logic       entry_eos_s;
    logic [1:0] entry_stereo_s;
    logic [5:0] entry_note_s;
    logic [5:0] entry_duration_s;
    logic       reserved_unused_s;

    // The last address in the song; a done here wraps the song and ends it.
    logic       last_entry_s;

    // Split the ROM word into its fields.
    always_comb begin
        entry_eos_s       = rom_data[15];
        entry_stereo_s    = rom_data[14:13];
        entry_note_s      = rom_data[12:7];
        entry_duration_s  = rom_data[6:1];
        reserved_unused_s = rom_data[0];
    end

    assign last_entry_s = (rom_addr == {SONG_ADDR_W{1'b1}});

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r             <= IDLE;
            rom_addr            <= {SONG_ADDR_W{1'b0}};
            note_to_load        <= 6'd0;
            duration_to_load    <= 6'd0;
            stereo_side_to_load <= 2'b00;
            load_new_note       <= 1'b0;
            play_enable         <= 1'b0;
            song_done           <= 1'b0;
        end else begin
            // play_enable tracks play regardless of sequencer state.
            play_enable <= play;

            if (restart) begin
                // Rewind; field registers keep their last values.
                state_r       <= IDLE;
                rom_addr      <= {SONG_ADDR_W{1'b0}};
                song_done     <= 1'b0;
                load_new_note <= 1'b0;
            end else begin
                // The load pulse is only ever raised on the DECODE->LOAD edge.
                load_new_note <= 1'b0;

                case (state_r)
                    IDLE: begin
                        if (play) begin
                            state_r <= FETCH;
                        end else begin
                            state_r <= IDLE;
                        end
                    end

                    FETCH: begin
                        // rom_addr held; ROM word appears during DECODE.
                        state_r <= DECODE;
                    end

                    DECODE: begin
                        if (entry_eos_s) begin
                            state_r   <= DONE;
                            song_done <= 1'b1;
                        end else begin
                            note_to_load        <= entry_note_s;
                            duration_to_load    <= entry_duration_s;
                            stereo_side_to_load <= entry_stereo_s;
                            load_new_note       <= 1'b1;
                            state_r             <= LOAD;
                        end
                    end

                    LOAD: begin
                        // A done arriving here belongs to no outstanding note.
                        state_r <= WAIT_DONE;
                    end

                    WAIT_DONE: begin
                        if (done_with_note) begin
                            if (last_entry_s) begin
                                rom_addr  <= {SONG_ADDR_W{1'b0}};
                                song_done <= 1'b1;
                                state_r   <= DONE;
                            end else begin
                                rom_addr <= rom_addr + SONG_ADDR_W'(1'b1);
                                if (play) begin
                                    state_r <= FETCH;
                                end else begin
                                    state_r <= IDLE;
                                end
                            end
                        end else begin
                            state_r <= WAIT_DONE;
                        end
                    end

                    DONE: begin
                        // Only restart or reset leaves DONE.
                        state_r <= DONE;
                    end

                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// ----------------------------------------------------------------------------
// tb_note_sequencer
//
// Directed bench for note_sequencer with a 4-entry song (SONG_ADDR_W = 2).
// A song-level model tracks which entry is due, how many cycles remain until
// its load pulse and whether the song has ended; a compare process checks
// every DUT output against it on each falling edge. Directed steps add
// hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk            = 1'b0;
    logic          reset_n        = 1'b1;
    logic          play           = 1'b0;
    logic          restart        = 1'b0;
    logic          done_with_note = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data       = 16'h0000;
    logic [5:0]    note_to_load;
    logic [5:0]    duration_to_load;
    logic [1:0]    stereo_side_to_load;
    logic          load_new_note;
    logic          play_enable;
    logic          song_done;

    logic [15:0]   rom [0:DEPTH-1];

    int   checks     = 0;
    int   errors     = 0;
    int   loads_seen = 0;
    logic chk_en     = 1'b0;

    note_sequencer #(.SONG_ADDR_W(AW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .play                (play),
        .restart             (restart),
        .rom_addr            (rom_addr),
        .rom_data            (rom_data),
        .note_to_load        (note_to_load),
        .duration_to_load    (duration_to_load),
        .stereo_side_to_load (stereo_side_to_load),
        .load_new_note       (load_new_note),
        .done_with_note      (done_with_note),
        .play_enable         (play_enable),
        .song_done           (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM, one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [15:0] ent(input logic eos, input logic [1:0] st,
                                        input logic [5:0] n, input logic [5:0] d);
        return {eos, st, n, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- song-level model ----------------
    // Modes: idle, counting down to the next entry's decode, note outstanding,
    // song finished.
    localparam int M_IDLE = 0, M_PIPE = 1, M_PLAY = 2, M_END = 3;
    int            m_mode  = M_IDLE;
    int            m_wait  = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [5:0]    m_note  = 6'd0;
    logic [5:0]    m_dur   = 6'd0;
    logic [1:0]    m_st    = 2'b00;
    logic          m_load  = 1'b0;
    logic          m_pe    = 1'b0;
    logic          m_done  = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode <= M_IDLE; m_wait <= 0; m_addr <= '0;
            m_note <= 6'd0; m_dur <= 6'd0; m_st <= 2'b00;
            m_load <= 1'b0; m_pe <= 1'b0; m_done <= 1'b0;
        end else begin
            m_pe   <= play;
            m_load <= 1'b0;
            if (restart) begin
                m_mode <= M_IDLE; m_addr <= '0; m_done <= 1'b0;
            end else begin
                case (m_mode)
                    M_IDLE: if (play) begin m_mode <= M_PIPE; m_wait <= 1; end
                    M_PIPE: begin
                        if (m_wait > 0) m_wait <= m_wait - 1;
                        else if (rom[m_addr][15]) begin m_mode <= M_END; m_done <= 1'b1; end
                        else begin
                            m_note <= rom[m_addr][12:7];
                            m_dur  <= rom[m_addr][6:1];
                            m_st   <= rom[m_addr][14:13];
                            m_load <= 1'b1;
                            m_mode <= M_PLAY;
                        end
                    end
                    M_PLAY: begin
                        // A done during the load pulse itself does not count.
                        if (done_with_note && !m_load) begin
                            if (int'(m_addr) == DEPTH - 1) begin
                                m_addr <= '0; m_done <= 1'b1; m_mode <= M_END;
                            end else begin
                                m_addr <= m_addr + 1'b1;
                                m_mode <= play ? M_PIPE : M_IDLE;
                                m_wait <= 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rom_addr", 16'(rom_addr), 16'(m_addr));
            check("cyc_note", 16'(note_to_load), 16'(m_note));
            check("cyc_duration", 16'(duration_to_load), 16'(m_dur));
            check("cyc_stereo", 16'(stereo_side_to_load), 16'(m_st));
            check("cyc_load", 16'(load_new_note), 16'(m_load));
            check("cyc_play_enable", 16'(play_enable), 16'(m_pe));
            check("cyc_song_done", 16'(song_done), 16'(m_done));
            if (load_new_note === 1'b1) loads_seen++;
        end
    end

    task automatic wait_load(input string name);
        int n = 0;
        while (load_new_note !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (load_new_note !== 1'b1) begin
            errors++;
            $display("FAIL %s: load_new_note=%b expected 1 within 20 cycles", name, load_new_note);
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done_with_note = 1'b1;
        @(negedge clk);
        done_with_note = 1'b0;
    endtask

    initial begin
        rom[0] = ent(1'b0, 2'b01, 6'd10, 6'd4);
        rom[1] = ent(1'b1, 2'b00, 6'd0, 6'd0);
        rom[2] = 16'h0000;
        rom[3] = 16'h0000;

        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_addr", 16'(rom_addr), 16'd0);
        check("reset_note", 16'(note_to_load), 16'd0);
        check("reset_load", 16'(load_new_note), 16'd0);
        check("reset_song_done", 16'(song_done), 16'd0);
        check("reset_play_enable", 16'(play_enable), 16'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single note then end of song.
        play = 1'b1;
        @(negedge clk); check("t1_fetch_no_load", 16'(load_new_note), 16'd0);
        @(negedge clk); check("t1_decode_no_load", 16'(load_new_note), 16'd0);
        @(negedge clk);
        check("t1_load", 16'(load_new_note), 16'd1);
        check("t1_note", 16'(note_to_load), 16'd10);
        check("t1_dur", 16'(duration_to_load), 16'd4);
        check("t1_stereo", 16'(stereo_side_to_load), 16'b01);
        check("t1_play_enable", 16'(play_enable), 16'd1);
        pulse_done();
        check("t1_addr_inc", 16'(rom_addr), 16'd1);
        repeat (2) @(negedge clk);
        check("t1_song_done", 16'(song_done), 16'd1);
        repeat (6) @(negedge clk);
        check("t1_load_count", 16'(loads_seen), 16'd1);

        // Spurious done during FETCH / DECODE / LOAD.
        rom[0] = ent(1'b0, 2'b10, 6'd5, 6'd3);
        rom[1] = ent(1'b0, 2'b01, 6'd33, 6'd0);
        rom[2] = ent(1'b0, 2'b10, 6'd63, 6'd63);
        rom[3] = ent(1'b1, 2'b00, 6'd0, 6'd0);
        play = 1'b0; restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        check("t2_restart_addr", 16'(rom_addr), 16'd0);
        check("t2_restart_song_done", 16'(song_done), 16'd0);
        play = 1'b1;
        @(negedge clk); done_with_note = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_load", 16'(load_new_note), 16'd1);
        check("t2_note", 16'(note_to_load), 16'd5);
        @(negedge clk); done_with_note = 1'b0;
        check("t2_spurious_addr", 16'(rom_addr), 16'd0);
        repeat (3) @(negedge clk);
        check("t2_spurious_addr_hold", 16'(rom_addr), 16'd0);
        check("t2_one_load", 16'(loads_seen), 16'd2);

        // Pause between notes.
        play = 1'b0;
        pulse_done();
        check("t3_pause_addr", 16'(rom_addr), 16'd1);
        repeat (4) @(negedge clk);
        check("t3_idle_no_load", 16'(loads_seen), 16'd2);
        play = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t3_load", 16'(load_new_note), 16'd1);
        check("t3_note", 16'(note_to_load), 16'd33);
        check("t3_dur_zero", 16'(duration_to_load), 16'd0);
        check("t3_stereo", 16'(stereo_side_to_load), 16'b01);
        pulse_done();
        check("t3_addr2", 16'(rom_addr), 16'd2);
        @(negedge clk); @(negedge clk);
        check("t3_load2_note", 16'(note_to_load), 16'd63);

        // Restart together with done while entry 2 plays: restart wins.
        @(negedge clk);
        restart = 1'b1; done_with_note = 1'b1; play = 1'b0;
        @(negedge clk);
        restart = 1'b0; done_with_note = 1'b0;
        check("t4_restart_addr", 16'(rom_addr), 16'd0);
        repeat (4) @(negedge clk);
        check("t4_idle_no_load", 16'(loads_seen), 16'd4);
        check("t4_fields_hold", 16'(note_to_load), 16'd63);
        play = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t4_reload", 16'(load_new_note), 16'd1);
        check("t4_reload_note", 16'(note_to_load), 16'd5);
        check("t4_reload_dur", 16'(duration_to_load), 16'd3);

        // Wrap after four non-eos entries.
        rom[3] = ent(1'b0, 2'b01, 6'd7, 6'd9);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) wait_load("t5_wait_load");
            if (k == 3) check("t5_entry3_note", 16'(note_to_load), 16'd7);
            pulse_done();
        end
        check("t5_wrap_song_done", 16'(song_done), 16'd1);
        check("t5_wrap_addr", 16'(rom_addr), 16'd0);
        repeat (6) @(negedge clk);
        check("t5_no_fifth_load", 16'(loads_seen), 16'd8);

        // Asynchronous reset during LOAD.
        play = 1'b0; restart = 1'b1;
        @(negedge clk); restart = 1'b0; play = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t6_load_before_reset", 16'(load_new_note), 16'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_load", 16'(load_new_note), 16'd0);
        check("t6_async_note", 16'(note_to_load), 16'd0);
        check("t6_async_stereo", 16'(stereo_side_to_load), 16'd0);
        check("t6_async_play_enable", 16'(play_enable), 16'd0);
        @(negedge clk);
        play = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_no_load", 16'(loads_seen), 16'd9);
        play = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t6_post_reset_load", 16'(load_new_note), 16'd1);
        check("t6_post_reset_note", 16'(note_to_load), 16'd5);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
